// File: rtl/lfsr_pkg.sv
// Shared types and the Galois LFSR step function for the dispenser.
package lfsr_pkg;

  typedef enum logic {INIT, READY} lfsr_ctl_state_e;

  localparam logic [3:0] LFSR4_TAPS_DEFAULT = 4'b0010;
  localparam int LFSR_MAX_W = 32;

  // One Galois step over the low w bits: the MSB feeds bit 0 and is XORed
  // into every tapped position on the way up.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
    input logic [LFSR_MAX_W-1:0] q,
    input logic [LFSR_MAX_W-1:0] taps,
    input int                    w
  );
    logic f;
    logic [LFSR_MAX_W-1:0] nxt;
    f      = q[w-1];
    nxt    = '0;
    nxt[0] = f;
    for (int i = 1; i < LFSR_MAX_W; i++)
      if (i < w) nxt[i] = q[i-1] ^ (taps[i] & f);
    return nxt;
  endfunction

endpackage

// File: rtl/lfsr_rr_dispenser_if.sv
// Requester-side bus of the dispenser: requests and seed load in, grant, word and busy out.
interface lfsr_rr_dispenser_if #(
  parameter int N = 4,
  parameter int W = 4
);
  logic [N-1:0] req_i;
  logic [N-1:0] gnt_o;
  logic [W-1:0] rnd_o;
  logic         seed_we_i;
  logic [W-1:0] seed_i;
  logic         busy_o;

  modport master (output req_i, seed_we_i, seed_i, input gnt_o, rnd_o, busy_o);
  modport slave  (input req_i, seed_we_i, seed_i, output gnt_o, rnd_o, busy_o);
endinterface

// File: rtl/lfsr_core.sv
// LFSR register with load/step controls; zero loads fall back to SEED so the
// register can never lock up at all-zeros.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int           W    = 4,
  parameter logic [W-1:0] TAPS = W'(LFSR4_TAPS_DEFAULT),
  parameter logic [W-1:0] SEED = W'(4'hF)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         step_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] state_o
);

  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_core: SEED must be non-zero");
  end

  logic [W-1:0] q, nxt;

  assign nxt     = W'(lfsr_next(LFSR_MAX_W'(q), LFSR_MAX_W'(TAPS), W));
  assign state_o = q;

  // Load wins over step; a zero load value is replaced by SEED.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       q <= SEED;
    else if (load_i) q <= (load_val_i == '0) ? SEED : load_val_i;
    else if (step_i) q <= nxt;
  end

endmodule

// File: rtl/lfsr_rr_dispenser.sv
// Round-robin dispenser of LFSR words: warm-up sequencing after reset or seed
// load, then one grant (and one LFSR step) per cycle while anyone requests.
module lfsr_rr_dispenser
  import lfsr_pkg::*;
#(
  parameter int           N      = 4,
  parameter int           W      = 4,
  parameter logic [W-1:0] TAPS   = W'(LFSR4_TAPS_DEFAULT),
  parameter logic [W-1:0] SEED   = W'(4'hF),
  parameter int           WARMUP = 2
) (
  input logic                clk_i,
  input logic                rst_i,
  lfsr_rr_dispenser_if.slave bus
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(WARMUP + 1);

  if (N < 2 || W < 3 || WARMUP < 1) begin : g_bad_params
    $error("lfsr_rr_dispenser: requires N>=2, W>=3, WARMUP>=1");
  end

  lfsr_ctl_state_e state, state_nxt;
  logic [CW-1:0]   warm_cnt;
  logic [PW-1:0]   rr_ptr, winner;
  logic            found, grant, step;
  logic [W-1:0]    lfsr;
  logic [N-1:0]    gnt;
  logic [W-1:0]    rnd;

  lfsr_core #(.W(W), .TAPS(TAPS), .SEED(SEED)) u_core (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .step_i     (step),
    .load_i     (bus.seed_we_i),
    .load_val_i (bus.seed_i),
    .state_o    (lfsr)
  );

  // First requester after rr_ptr, wrapping; the last winner is checked last.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= N; k++) begin
      if (!found && bus.req_i[(int'(rr_ptr) + k) % N]) begin
        found  = 1'b1;
        winner = PW'((int'(rr_ptr) + k) % N);
      end
    end
  end

  // Next state and LFSR step control; a seed load suppresses any grant.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    step      = 1'b0;
    if (bus.seed_we_i) begin
      state_nxt = INIT;
    end else begin
      case (state)
        INIT: begin
          step = 1'b1;
          if (warm_cnt == CW'(WARMUP - 1)) state_nxt = READY;
        end
        READY: begin
          if (found) begin
            grant = 1'b1;
            step  = 1'b1;
          end
        end
        default: state_nxt = INIT;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= INIT;
    else       state <= state_nxt;
  end

  // Warm-up step counter, restarted by a seed load.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)               warm_cnt <= '0;
    else if (bus.seed_we_i)  warm_cnt <= '0;
    else if (state == INIT)  warm_cnt <= warm_cnt + 1'b1;
  end

  // Round-robin pointer moves only on a grant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      rr_ptr <= PW'(N - 1);
    else if (grant) rr_ptr <= winner;
  end

  // Registered grant pulse and the word handed out with it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gnt <= '0;
      rnd <= '0;
    end else begin
      gnt <= grant ? (N'(1) << winner) : '0;
      rnd <= grant ? lfsr : '0;
    end
  end

  assign bus.gnt_o  = gnt;
  assign bus.rnd_o  = rnd;
  assign bus.busy_o = (state == INIT);

endmodule

// File: tb/tb_lfsr_rr_dispenser.sv
// Bench for lfsr_rr_dispenser: directed scenarios plus randomized traffic
// checked against a polynomial/round-robin reference model.
module tb_lfsr_rr_dispenser;
  localparam int N = 4;
  localparam int W = 4;
  localparam int WARMUP = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int errors = 0;

  lfsr_rr_dispenser_if #(.N(N), .W(W)) bus();
  lfsr_rr_dispenser #(.N(N), .W(W)) dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  // Reference model: LFSR as multiplication by x modulo x^4+x+1.
  bit m_init;
  int m_warm, m_lfsr, m_ptr, e_gnt, e_rnd;

  function automatic int mstep(int v);
    int r;
    r = v << 1;
    if ((r & 16) != 0) r = r ^ 'h13;
    return r;
  endfunction

  function automatic void model_reset();
    m_init = 1; m_warm = 0; m_lfsr = 15; m_ptr = N - 1; e_gnt = 0; e_rnd = 0;
  endfunction

  function automatic void model_edge();
    int r;
    r = int'(bus.req_i);
    e_gnt = 0; e_rnd = 0;
    if (bus.seed_we_i) begin
      m_lfsr = (bus.seed_i == 0) ? 15 : int'(bus.seed_i);
      m_warm = 0; m_init = 1;
    end else if (m_init) begin
      m_lfsr = mstep(m_lfsr);
      m_warm++;
      if (m_warm == WARMUP) m_init = 0;
    end else if (r != 0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (r[c]) begin m_ptr = c; break; end
      end
      e_gnt = 1 << m_ptr;
      e_rnd = m_lfsr;
      m_lfsr = mstep(m_lfsr);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_i = '0; bus.seed_we_i = 1'b0; bus.seed_i = '0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int busy_exp[5];
    busy_exp = '{1, 1, 0, 0, 0};
    rst = 1'b1;
    bus.req_i = '0; bus.seed_we_i = 1'b0; bus.seed_i = '0;
    model_reset();
    #2;
    vectors++;
    if (bus.gnt_o !== '0 || bus.rnd_o !== '0 || bus.busy_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: gnt=%b rnd=%h busy=%b, want 0000/0/1", bus.gnt_o, bus.rnd_o, bus.busy_o);
    end
    @(negedge clk); rst = 1'b0;
    // busy visible for the cycle of reset release plus one warm-up step
    for (int i = 1; i < 5; i++) begin
      tick();
      vectors++;
      if (bus.busy_o !== busy_exp[i][0] || bus.gnt_o !== '0) begin
        errors++;
        $display("FAIL reset_warmup[%0d]: busy=%b gnt=%b, want busy=%0d gnt=0", i, bus.busy_o, bus.gnt_o, busy_exp[i]);
      end
    end
  endtask

  task automatic test_single();
    int seq[6];
    seq = '{9, 1, 2, 4, 8, 3};
    bus.req_i = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++;
      if (bus.gnt_o !== 4'b0001 || int'(bus.rnd_o) != seq[i]) begin
        errors++;
        $display("FAIL single[%0d]: gnt=%b rnd=%h, want 0001/%h", i, bus.gnt_o, bus.rnd_o, seq[i]);
      end
    end
    bus.req_i = '0;
  endtask

  task automatic test_all();
    int gseq[5], rseq[5];
    gseq = '{1, 2, 4, 8, 1};
    rseq = '{9, 1, 2, 4, 8};
    do_reset();
    bus.req_i = 4'b1111;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (int'(bus.gnt_o) != gseq[i] || int'(bus.rnd_o) != rseq[i] || bus.busy_o !== 1'b0) begin
        errors++;
        $display("FAIL all_req[%0d]: gnt=%b rnd=%h, want %b/%h", i, bus.gnt_o, bus.rnd_o, gseq[i][3:0], rseq[i]);
      end
    end
  endtask

  task automatic test_seed();
    bus.req_i = 4'b0010; bus.seed_we_i = 1'b1; bus.seed_i = 4'h5;
    tick();
    bus.seed_we_i = 1'b0;
    vectors++;
    if (bus.gnt_o !== '0 || bus.busy_o !== 1'b1) begin
      errors++;
      $display("FAIL seed_no_grant: gnt=%b busy=%b, want 0000/1", bus.gnt_o, bus.busy_o);
    end
    tick();
    vectors++;
    if (bus.busy_o !== 1'b1 || bus.gnt_o !== '0) begin
      errors++;
      $display("FAIL seed_busy2: busy=%b gnt=%b, want 1/0000", bus.busy_o, bus.gnt_o);
    end
    tick();
    vectors++;
    if (bus.busy_o !== 1'b0 || bus.gnt_o !== '0) begin
      errors++;
      $display("FAIL seed_ready: busy=%b gnt=%b, want 0/0000", bus.busy_o, bus.gnt_o);
    end
    tick();
    vectors++;
    if (bus.gnt_o !== 4'b0010 || int'(bus.rnd_o) != mstep(mstep(5))) begin
      errors++;
      $display("FAIL seed_first_word: gnt=%b rnd=%h, want 0010/%h", bus.gnt_o, bus.rnd_o, mstep(mstep(5)));
    end
  endtask

  task automatic test_zero_seed();
    bus.req_i = 4'b0100; bus.seed_we_i = 1'b1; bus.seed_i = 4'h0;
    tick();
    bus.seed_we_i = 1'b0;
    tick(); tick(); tick();
    vectors++;
    if (bus.gnt_o !== 4'b0100 || bus.rnd_o !== 4'h9) begin
      errors++;
      $display("FAIL zero_seed: gnt=%b rnd=%h, want 0100/9", bus.gnt_o, bus.rnd_o);
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    bus.req_i = 4'b1111;
    guard = 0;
    tick();
    while (bus.gnt_o == '0 && guard < 20) begin tick(); guard++; end
    vectors++;
    if (bus.gnt_o == '0) begin
      errors++;
      $display("FAIL reset_mid_setup: no grant within 20 cycles, gnt=%b want nonzero", bus.gnt_o);
    end
    rst = 1'b1;
    model_reset();
    #1;
    vectors++;
    if (bus.gnt_o !== '0 || bus.rnd_o !== '0 || bus.busy_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_clear: gnt=%b rnd=%h busy=%b, want 0000/0/1", bus.gnt_o, bus.rnd_o, bus.busy_o);
    end
    @(negedge clk); rst = 1'b0;
    tick(); tick();
    vectors++;
    if (bus.busy_o !== 1'b0 || bus.gnt_o !== '0) begin
      errors++;
      $display("FAIL reset_mid_warm: busy=%b gnt=%b, want 0/0000", bus.busy_o, bus.gnt_o);
    end
    tick();
    vectors++;
    if (bus.gnt_o !== 4'b0001 || bus.rnd_o !== 4'h9) begin
      errors++;
      $display("FAIL reset_mid_restart: gnt=%b rnd=%h, want 0001/9", bus.gnt_o, bus.rnd_o);
    end
  endtask

  task automatic test_period();
    int seen[16];
    do_reset();
    bus.req_i = 4'b0001;
    tick(); tick();
    for (int i = 0; i < 16; i++) begin
      tick();
      seen[i] = int'(bus.rnd_o);
      vectors++;
      if (bus.gnt_o !== 4'b0001 || seen[i] == 0) begin
        errors++;
        $display("FAIL period_word[%0d]: gnt=%b rnd=%h, want 0001/nonzero", i, bus.gnt_o, bus.rnd_o);
      end
      for (int j = 0; j < i && i < 15; j++) begin
        if (seen[j] == seen[i]) begin
          vectors++;
          errors++;
          $display("FAIL period_repeat: word %0d = %h equals word %0d, want distinct", i, seen[i], j);
        end
      end
    end
    vectors++;
    if (seen[15] != seen[0]) begin
      errors++;
      $display("FAIL period_wrap: word15=%h, want %h", seen[15], seen[0]);
    end
    bus.req_i = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bus.req_i     = N'($urandom_range(0, 15));
      bus.seed_we_i = ($urandom_range(0, 19) == 0);
      bus.seed_i    = W'($urandom_range(0, 15));
      tick();
      vectors++;
      if (int'(bus.gnt_o) != e_gnt || int'(bus.rnd_o) != e_rnd || bus.busy_o !== m_init) begin
        errors++;
        $display("FAIL random[%0d]: gnt=%b rnd=%h busy=%b, want %b/%h/%0d",
                 i, bus.gnt_o, bus.rnd_o, bus.busy_o, e_gnt[3:0], e_rnd, m_init);
      end
    end
    bus.seed_we_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all();
    test_seed();
    test_zero_seed();
    test_reset_mid();
    test_period();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
